// File: rtl/commit_trace_if.sv
// Commit-lane, trap and drain-side signals of the commit trace buffer.
// The buffer attaches through the slave modport; the core/checker side attaches through master.
interface commit_trace_if #(
  parameter int unsigned COMMITS = 2,
  parameter int unsigned XLEN    = 64,
  parameter int unsigned DEPTH   = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [COMMITS-1:0]      in_valid;
  logic [COMMITS*XLEN-1:0] in_pc;
  logic [COMMITS*32-1:0]   in_insn;
  logic [COMMITS-1:0]      in_wen;
  logic [COMMITS-1:0]      in_wfpr;
  logic [COMMITS*5-1:0]    in_waddr;
  logic [COMMITS*XLEN-1:0] in_wdata;
  logic                    trap_valid;
  logic [XLEN-1:0]         trap_cause;

  logic                    out_valid;
  logic                    out_ready;
  logic                    out_kind;
  logic [XLEN-1:0]         out_pc;
  logic [31:0]             out_insn;
  logic                    out_wen;
  logic                    out_wfpr;
  logic [4:0]              out_waddr;
  logic [XLEN-1:0]         out_wdata;
  logic                    stall_req;
  logic                    overflow;
  logic [CNT_W-1:0]        count;

  modport master (
    output in_valid, in_pc, in_insn, in_wen, in_wfpr, in_waddr, in_wdata,
    output trap_valid, trap_cause, out_ready,
    input  out_valid, out_kind, out_pc, out_insn, out_wen, out_wfpr, out_waddr, out_wdata,
    input  stall_req, overflow, count
  );

  modport slave (
    input  in_valid, in_pc, in_insn, in_wen, in_wfpr, in_waddr, in_wdata,
    input  trap_valid, trap_cause, out_ready,
    output out_valid, out_kind, out_pc, out_insn, out_wen, out_wfpr, out_waddr, out_wdata,
    output stall_req, overflow, count
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Compacts up to COMMITS retirements plus one trap per cycle into an in-order FIFO
// and drains one record per out_valid/out_ready handshake to the cosim checker.
module commit_trace_buffer #(
  parameter int unsigned COMMITS = 2,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned XLEN    = 64
) (
  input  logic          clock,
  input  logic          reset,
  commit_trace_if.slave bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SLOT_W = $clog2(COMMITS + 2);
  localparam int unsigned SLOTS  = 2 ** SLOT_W;

  typedef struct packed {
    logic            kind;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            wen;
    logic            wfpr;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
  } record_t;

  record_t          mem [DEPTH];
  record_t          cand [SLOTS];
  record_t          head_rec;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic [SLOT_W-1:0] n_in;
  logic [CNT_W-1:0] n_ext, free_slots, written;
  logic             drop, deq, out_valid_c;

  // Pack valid lanes in ascending order with no gaps; the trap record goes last.
  always_comb begin
    for (int s = 0; s < int'(SLOTS); s++) cand[s] = '0;
    n_in = '0;
    for (int i = 0; i < int'(COMMITS); i++) begin
      if (bus.in_valid[i]) begin
        cand[n_in].pc   = bus.in_pc[i*XLEN +: XLEN];
        cand[n_in].insn = bus.in_insn[i*32 +: 32];
        if (bus.in_wen[i]) begin
          cand[n_in].wen   = 1'b1;
          cand[n_in].wfpr  = bus.in_wfpr[i];
          cand[n_in].waddr = bus.in_waddr[i*5 +: 5];
          cand[n_in].wdata = bus.in_wdata[i*XLEN +: XLEN];
        end
        n_in = n_in + SLOT_W'(1);
      end
    end
    if (bus.trap_valid) begin
      cand[n_in].kind  = 1'b1;
      cand[n_in].wdata = bus.trap_cause;
      n_in = n_in + SLOT_W'(1);
    end
  end

  // Space is judged against the pre-dequeue count, so a same-cycle pop never makes room.
  assign n_ext       = CNT_W'(n_in);
  assign free_slots  = CNT_W'(DEPTH) - count_q;
  assign drop        = n_ext > free_slots;
  assign written     = drop ? free_slots : n_ext;
  assign out_valid_c = count_q != '0;
  assign deq         = out_valid_c && bus.out_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_q + PTR_W'(deq);
      tail_q     <= tail_q + PTR_W'(written);
      count_q    <= count_q + written - CNT_W'(deq);
      overflow_q <= overflow_q | drop;
    end
  end

  // Storage needs no reset: every read is gated by a nonzero count.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j <= int'(COMMITS); j++) begin
        if (CNT_W'(j) < written) mem[tail_q + PTR_W'(j)] <= cand[SLOT_W'(j)];
      end
    end
  end

  assign head_rec      = out_valid_c ? mem[head_q] : '0;
  assign bus.out_valid = out_valid_c;
  assign bus.out_kind  = head_rec.kind;
  assign bus.out_pc    = head_rec.pc;
  assign bus.out_insn  = head_rec.insn;
  assign bus.out_wen   = head_rec.wen;
  assign bus.out_wfpr  = head_rec.wfpr;
  assign bus.out_waddr = head_rec.waddr;
  assign bus.out_wdata = head_rec.wdata;
  assign bus.stall_req = free_slots < CNT_W'(COMMITS + 1);
  assign bus.overflow  = overflow_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: reset, compaction, ordering, backpressure,
// overflow, mid-stream reset and sustained enqueue/dequeue across pointer wrap.
module tb_commit_trace_buffer;
  localparam int unsigned COMMITS = 2;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned XLEN    = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  commit_trace_if #(.COMMITS(COMMITS), .XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  commit_trace_buffer #(.COMMITS(COMMITS), .DEPTH(DEPTH), .XLEN(XLEN)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.in_valid   = '0;
    bus.in_pc      = '0;
    bus.in_insn    = '0;
    bus.in_wen     = '0;
    bus.in_wfpr    = '0;
    bus.in_waddr   = '0;
    bus.in_wdata   = '0;
    bus.trap_valid = 1'b0;
    bus.trap_cause = '0;
  endtask

  task automatic set_lane(input int l, input logic [63:0] pc, input logic [31:0] insn,
                          input logic wen, input logic wfpr, input logic [4:0] waddr,
                          input logic [63:0] wdata);
    bus.in_valid[l]          = 1'b1;
    bus.in_pc[l*64 +: 64]    = pc;
    bus.in_insn[l*32 +: 32]  = insn;
    bus.in_wen[l]            = wen;
    bus.in_wfpr[l]           = wfpr;
    bus.in_waddr[l*5 +: 5]   = waddr;
    bus.in_wdata[l*64 +: 64] = wdata;
  endtask

  function automatic logic [63:0] seq_pc(input int k);
    return 64'h1000 + 64'(4 * k);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    set_lane(0, 64'h80000000, 32'h13, 1'b1, 1'b0, 5'd3, 64'd7);
    set_lane(1, 64'h80000004, 32'h13, 1'b1, 1'b0, 5'd4, 64'd8);
    bus.trap_valid = 1'b1;
    bus.trap_cause = 64'd5;
    step();
    step();
    vectors++;
    if (bus.count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus.count); end
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    vectors++;
    if ({bus.out_kind, bus.out_pc, bus.out_insn, bus.out_wen, bus.out_wfpr, bus.out_waddr, bus.out_wdata} !== '0) begin
      miscompares++; $display("FAIL reset_out_fields got pc=%0h wdata=%0h want all zero", bus.out_pc, bus.out_wdata);
    end
    vectors++;
    if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %0b want 0", bus.overflow); end
    vectors++;
    if (bus.stall_req !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %0b want 0", bus.stall_req); end
    reset = 1'b1;
    idle();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_compaction();
    bus.in_valid = 2'b10;
    set_lane(1, 64'h80000004, 32'h00a00093, 1'b1, 1'b0, 5'd1, 64'd10);
    bus.in_valid[0] = 1'b0;
    step();
    idle();
    vectors++;
    if (bus.out_pc !== 64'h80000004) begin miscompares++; $display("FAIL compact_pc got %0h want 80000004", bus.out_pc); end
    vectors++;
    if (bus.out_waddr !== 5'd1) begin miscompares++; $display("FAIL compact_waddr got %0d want 1", bus.out_waddr); end
    vectors++;
    if (bus.out_wdata !== 64'd10) begin miscompares++; $display("FAIL compact_wdata got %0d want 10", bus.out_wdata); end
    vectors++;
    if (bus.out_insn !== 32'h00a00093) begin miscompares++; $display("FAIL compact_insn got %0h want a00093", bus.out_insn); end
    vectors++;
    if (bus.count !== 5'd1) begin miscompares++; $display("FAIL compact_count got %0d want 1", bus.count); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 64'd0) begin
      miscompares++; $display("FAIL compact_drain got valid=%0b pc=%0h want 0/0", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_ordering();
    set_lane(0, 64'h80000000, 32'h00000013, 1'b0, 1'b1, 5'd5, 64'h55);
    set_lane(1, 64'h80000004, 32'h00a00093, 1'b1, 1'b0, 5'd1, 64'd10);
    bus.trap_valid = 1'b1;
    bus.trap_cause = 64'd2;
    bus.out_ready  = 1'b0;
    step();
    idle();
    vectors++;
    if (bus.count !== 5'd3) begin miscompares++; $display("FAIL order_count got %0d want 3", bus.count); end
    vectors++;
    if (bus.out_pc !== 64'h80000000) begin miscompares++; $display("FAIL order_head0_pc got %0h want 80000000", bus.out_pc); end
    vectors++;
    if ({bus.out_wen, bus.out_wfpr, bus.out_waddr, bus.out_wdata} !== '0) begin
      miscompares++; $display("FAIL order_nowen_fields got wfpr=%0b waddr=%0d wdata=%0h want 0", bus.out_wfpr, bus.out_waddr, bus.out_wdata);
    end
    step();
    vectors++;
    if (bus.out_pc !== 64'h80000000 || bus.count !== 5'd3) begin
      miscompares++; $display("FAIL order_hold got pc=%0h count=%0d want 80000000/3", bus.out_pc, bus.count);
    end
    bus.out_ready = 1'b1;
    step();
    vectors++;
    if (bus.out_pc !== 64'h80000004 || bus.out_wdata !== 64'd10 || bus.count !== 5'd2) begin
      miscompares++; $display("FAIL order_head1 got pc=%0h wdata=%0d count=%0d want 80000004/10/2", bus.out_pc, bus.out_wdata, bus.count);
    end
    step();
    vectors++;
    if (bus.out_kind !== 1'b1 || bus.out_wdata !== 64'd2 || bus.out_pc !== 64'd0 || bus.out_insn !== 32'd0) begin
      miscompares++; $display("FAIL order_trap got kind=%0b wdata=%0h pc=%0h insn=%0h want 1/2/0/0", bus.out_kind, bus.out_wdata, bus.out_pc, bus.out_insn);
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.count !== 5'd0) begin
      miscompares++; $display("FAIL order_empty got valid=%0b count=%0d want 0/0", bus.out_valid, bus.count);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 6; c++) begin
      set_lane(0, seq_pc(2*c), 32'h13, 1'b1, 1'b0, 5'd2, 64'(2*c));
      set_lane(1, seq_pc(2*c+1), 32'h13, 1'b1, 1'b0, 5'd2, 64'(2*c+1));
      step();
    end
    idle();
    set_lane(0, seq_pc(12), 32'h13, 1'b1, 1'b0, 5'd2, 64'd12);
    step();
    idle();
    vectors++;
    if (bus.count !== 5'd13 || bus.stall_req !== 1'b0) begin
      miscompares++; $display("FAIL bp_13 got count=%0d stall=%0b want 13/0", bus.count, bus.stall_req);
    end
    for (int h = 0; h < 3; h++) begin
      step();
      vectors++;
      if (bus.out_pc !== seq_pc(0) || bus.out_wdata !== 64'd0 || bus.out_valid !== 1'b1) begin
        miscompares++; $display("FAIL bp_hold got pc=%0h wdata=%0d valid=%0b want 1000/0/1", bus.out_pc, bus.out_wdata, bus.out_valid);
      end
    end
    set_lane(0, seq_pc(13), 32'h13, 1'b1, 1'b0, 5'd2, 64'd13);
    step();
    idle();
    vectors++;
    if (bus.count !== 5'd14 || bus.stall_req !== 1'b1) begin
      miscompares++; $display("FAIL bp_14 got count=%0d stall=%0b want 14/1", bus.count, bus.stall_req);
    end
    set_lane(0, seq_pc(14), 32'h13, 1'b1, 1'b0, 5'd2, 64'd14);
    step();
    idle();
  endtask

  task automatic test_overflow();
    vectors++;
    if (bus.count !== 5'd15 || bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL ovf_pre got count=%0d overflow=%0b want 15/0", bus.count, bus.overflow);
    end
    set_lane(0, seq_pc(15), 32'h13, 1'b1, 1'b0, 5'd2, 64'd15);
    set_lane(1, seq_pc(16), 32'h13, 1'b1, 1'b0, 5'd2, 64'd16);
    step();
    idle();
    vectors++;
    if (bus.count !== 5'd16 || bus.overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_full got count=%0d overflow=%0b want 16/1", bus.count, bus.overflow);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (bus.out_pc !== seq_pc(k) || bus.out_wdata !== 64'(k)) begin
        miscompares++; $display("FAIL ovf_drain_%0d got pc=%0h wdata=%0d want %0h/%0d", k, bus.out_pc, bus.out_wdata, seq_pc(k), k);
      end
      step();
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.count !== 5'd0) begin
      miscompares++; $display("FAIL ovf_dropped got valid=%0b count=%0d want 0/0", bus.out_valid, bus.count);
    end
    step();
    vectors++;
    if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %0b want 1", bus.overflow); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    set_lane(0, 64'h3000, 32'h13, 1'b1, 1'b0, 5'd6, 64'd1);
    set_lane(1, 64'h3004, 32'h13, 1'b1, 1'b0, 5'd7, 64'd2);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    idle();
    vectors++;
    if (bus.count !== 5'd0 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL midrst got count=%0d valid=%0b overflow=%0b want 0/0/0", bus.count, bus.out_valid, bus.overflow);
    end
    step();
    vectors++;
    if (bus.count !== 5'd0 || bus.out_pc !== 64'd0) begin
      miscompares++; $display("FAIL midrst_after got count=%0d pc=%0h want 0/0", bus.count, bus.out_pc);
    end
  endtask

  task automatic test_back_to_back();
    set_lane(0, 64'h2000, 32'h13, 1'b1, 1'b0, 5'd8, 64'd0);
    step();
    idle();
    vectors++;
    if (bus.count !== 5'd1 || bus.out_pc !== 64'h2000) begin
      miscompares++; $display("FAIL b2b_first got count=%0d pc=%0h want 1/2000", bus.count, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      set_lane(0, 64'h2000 + 64'(4*i), 32'h13, 1'b1, 1'b0, 5'd8, 64'(i));
      step();
      vectors++;
      if (bus.count !== 5'd1 || bus.out_pc !== 64'h2000 + 64'(4*i) || bus.out_wdata !== 64'(i)) begin
        miscompares++; $display("FAIL b2b_%0d got count=%0d pc=%0h wdata=%0d want 1/%0h/%0d", i, bus.count, bus.out_pc, bus.out_wdata, 64'h2000 + 64'(4*i), i);
      end
    end
    idle();
    step();
    vectors++;
    if (bus.count !== 5'd0 || bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_empty got count=%0d valid=%0b want 0/0", bus.count, bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    idle();
    bus.out_ready = 1'b0;
    test_reset();
    test_compaction();
    test_ordering();
    test_backpressure();
    test_overflow();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
